// File: rtl/datacache_writeback_buffer.sv
// datacache_writeback_buffer: dirty-line eviction FIFO draining to pmem one line at a time.
// Define DATACACHE_WB_FORWARD_EN to build the pending-line lookup/forwarding comparators.
module datacache_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     evict_valid,
    output logic                     evict_ready,
    input  logic [31:0]              evict_address,
    input  logic [LINE_W-1:0]        evict_data,
    input  logic                     evict_dirty,
    output logic [31:0]              pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    output logic                     pmem_write,
    input  logic                     pmem_resp,
    input  logic [31:0]              lookup_address,
    output logic                     lookup_hit,
    output logic [LINE_W-1:0]        lookup_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_nx;
    logic [26:0] tag [DEPTH];
    logic [LINE_W-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0] head, tail, coal_idx;
    logic [CW-1:0] cnt;
    logic [26:0] evict_tag;
    logic push, pop, coal, unused;
    assign evict_tag = evict_address[31:5];
    assign evict_ready = cnt != CW'(DEPTH);
    assign push = evict_valid && evict_ready && evict_dirty;
    assign pop = state == WRITE && pmem_resp;
    assign count = cnt;
    assign busy = cnt != '0;
    assign pmem_write = state == WRITE;
    assign pmem_address = busy ? {tag[head], 5'b00000} : '0;
    assign pmem_wdata = busy ? data[head] : '0;
    assign unused = ^{evict_address[4:0], lookup_address};
    // the head being written to memory must never change, so it is excluded from coalescing
    always_comb begin
        coal = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i] && tag[i] == evict_tag && !(state == WRITE && PW'(i) == head)) begin
                coal = 1'b1;
                coal_idx = PW'(i);
            end
    end
    always_comb begin
        state_nx = state == IDLE ? (busy ? WRITE : IDLE) : (pmem_resp ? IDLE : WRITE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            cnt <= '0;
            vld <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                vld[head] <= 1'b0;
                head <= head + PW'(1);
            end
            if (push && !coal) begin
                vld[tail] <= 1'b1;
                tail <= tail + PW'(1);
            end
            cnt <= cnt + CW'(push && !coal) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            tag[coal ? coal_idx : tail] <= evict_tag;
            data[coal ? coal_idx : tail] <= evict_data;
        end
    end
`ifdef DATACACHE_WB_FORWARD_EN
    logic [PW-1:0] idx;
    // scan oldest to youngest so the last match (youngest) wins
    always_comb begin
        lookup_hit = 1'b0;
        lookup_data = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (vld[idx] && tag[idx] == lookup_address[31:5]) begin
                lookup_hit = 1'b1;
                lookup_data = data[idx];
            end
        end
    end
`else
    assign lookup_hit = 1'b0;
    assign lookup_data = '0;
`endif
endmodule

// File: tb/tb_datacache_writeback_buffer.sv
// tb_datacache_writeback_buffer: directed and random stimulus against a queue-based model of the write-back buffer.
module tb_datacache_writeback_buffer;
    localparam int DEPTH = 4;
    localparam int LW = 256;
`ifdef DATACACHE_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic evict_valid = 0, evict_dirty = 0, pmem_resp = 0;
    logic [31:0] evict_address = 0, lookup_address = 32'hFFFF_FFE0;
    logic [LW-1:0] evict_data = 0;
    logic evict_ready, pmem_write, lookup_hit, busy;
    logic [31:0] pmem_address;
    logic [LW-1:0] pmem_wdata, lookup_data;
    logic [2:0] count;
    int total = 0, bad = 0;
    typedef struct packed { logic [26:0] tag; logic [LW-1:0] data; } ent_t;
    ent_t mq[$];
    bit mw = 0;
    logic [287:0] dlog[$];
    logic [LW-1:0] A, B, C, D, E, F, X;

    datacache_writeback_buffer #(.DEPTH(DEPTH), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst), .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_address(evict_address), .evict_data(evict_data), .evict_dirty(evict_dirty),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .lookup_address(lookup_address), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rnd256();
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < LW / 32; i++) r = {r[LW-33:0], 32'($urandom)};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [287:0] obs, input logic [287:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic check_all();
        logic lh;
        logic [LW-1:0] ld;
        lh = 1'b0;
        ld = '0;
        if (FWD)
            foreach (mq[k]) if (mq[k].tag == lookup_address[31:5]) begin lh = 1'b1; ld = mq[k].data; end
        chk("pmem_write", 288'(pmem_write), 288'(mw));
        chk("busy", 288'(busy), 288'(mq.size() != 0));
        chk("count", 288'(count), 288'(mq.size()));
        chk("evict_ready", 288'(evict_ready), 288'(mq.size() != DEPTH));
        chk("pmem_address", 288'(pmem_address), mq.size() != 0 ? 288'({mq[0].tag, 5'b00000}) : 288'(0));
        chk("pmem_wdata", 288'(pmem_wdata), mq.size() != 0 ? 288'(mq[0].data) : 288'(0));
        chk("lookup_hit", 288'(lookup_hit), 288'(lh));
        chk("lookup_data", 288'(lookup_data), 288'(ld));
    endtask

    task automatic model_update(input logic v, input logic [31:0] a, input logic [LW-1:0] d,
                                input logic dty, input logic r);
        int j;
        bit acc, pp, was;
        acc = v && mq.size() != DEPTH;
        pp = mw && r;
        was = mq.size() != 0;
        j = -1;
        if (acc && dty)
            foreach (mq[k]) if (mq[k].tag == a[31:5] && !(mw && k == 0)) j = k;
        if (j >= 0) mq[j].data = d;
        if (pp) void'(mq.pop_front());
        if (acc && dty && j < 0) mq.push_back({a[31:5], d});
        mw = mw ? !r : was;
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [LW-1:0] d,
                        input logic dty, input logic r, input logic [31:0] la);
        evict_valid = v; evict_address = a; evict_data = d; evict_dirty = dty;
        pmem_resp = r; lookup_address = la;
        #1;
        check_all();
        if (pmem_write && r) dlog.push_back({pmem_address, pmem_wdata});
        @(posedge clk);
        model_update(v, a, d, dty, r);
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        step(1'b0, 32'h0, '0, 1'b0, r, 32'hFFFF_FFE0);
    endtask

    task automatic push(input logic [31:0] a, input logic [LW-1:0] d);
        step(1'b1, a, d, 1'b1, 1'b0, 32'hFFFF_FFE0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mq.size() != 0; i++) idle(1'b1);
        chk("drain_done", 288'(busy), 288'(0));
        idle(1'b0);
    endtask

    initial begin
        A = rnd256(); B = rnd256(); C = rnd256(); D = rnd256();
        E = rnd256(); F = rnd256(); X = rnd256();
        @(negedge clk); @(negedge clk);
        check_all();
        rst = 1'b0;
        // single dirty eviction and its write latency
        push(32'h0000_1234, A);
        idle(1'b0);
        chk("latency_write", 288'(pmem_write), 288'(1));
        chk("latency_addr", 288'(pmem_address), 288'(32'h0000_1220));
        chk("latency_data", 288'(pmem_wdata), 288'(A));
        idle(1'b0); idle(1'b0); idle(1'b0);
        idle(1'b1);
        chk("after_resp_count", 288'(count), 288'(0));
        chk("after_resp_write", 288'(pmem_write), 288'(0));
        // clean eviction
        step(1'b1, 32'h40, B, 1'b0, 1'b0, 32'hFFFF_FFE0);
        idle(1'b0); idle(1'b0);
        // fill with memory stalled, then drain in order
        dlog.delete();
        push(32'h100, A); push(32'h200, B); push(32'h300, C); push(32'h400, D);
        step(1'b1, 32'h500, E, 1'b1, 1'b0, 32'hFFFF_FFE0);
        chk("full_ready", 288'(evict_ready), 288'(0));
        idle(1'b1);
        chk("ready_after_resp", 288'(evict_ready), 288'(1));
        drain();
        chk("fill_nwrites", 288'(dlog.size()), 288'(4));
        for (int i = 0; i < 4 && i < dlog.size(); i++)
            chk("fill_order", 288'(dlog[i][287:256]), 288'(32'h100 * (i + 1)));
        // coalescing behind and into an in-flight head
        dlog.delete();
        push(32'h100, X);
        push(32'h200, B);
        push(32'h200, C);
        chk("coalesce_count", 288'(count), 288'(2));
        push(32'h100, D);
        chk("realloc_count", 288'(count), 288'(3));
        drain();
        chk("coal_nwrites", 288'(dlog.size()), 288'(3));
        if (dlog.size() == 3) begin
            chk("coal_w0", dlog[0], {32'h100, X});
            chk("coal_w1", dlog[1], {32'h200, C});
            chk("coal_w2", dlog[2], {32'h100, D});
        end
        // forwarding
        push(32'h300, E);
        step(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0000_0314);
        chk("fwd_hit", 288'(lookup_hit), 288'(FWD));
        chk("fwd_data", 288'(lookup_data), FWD ? 288'(E) : 288'(0));
        drain();
        step(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0000_0314);
        chk("fwd_gone", 288'(lookup_hit), 288'(0));
        // asynchronous reset during a write
        push(32'h500, F);
        idle(1'b0);
        chk("pre_reset_write", 288'(pmem_write), 288'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_write", 288'(pmem_write), 288'(0));
        chk("rst_busy", 288'(busy), 288'(0));
        chk("rst_count", 288'(count), 288'(0));
        chk("rst_ready", 288'(evict_ready), 288'(1));
        chk("rst_addr", 288'(pmem_address), 288'(0));
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mw = 0;
        idle(1'b0); idle(1'b1); idle(1'b0);
        // random traffic over a small address set to provoke coalescing
        for (int n = 0; n < 400; n++)
            step(1'($urandom), 32'h100 * $urandom_range(1, 6) + $urandom_range(0, 31), rnd256(),
                 1'($urandom % 4 != 0), 1'($urandom % 3 == 0),
                 32'h100 * $urandom_range(1, 6) + $urandom_range(0, 31));
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/datacache_writeback_buffer.md
Name: datacache_writeback_buffer

Overview:
- Drain side of the data-cache eviction path. Accepts evicted 256-bit lines (line-aligned address, data, dirty flag) from the victim stage.
- Clean lines are discarded. Dirty lines are queued in a small FIFO and written to physical memory, one line at a time, over the pmem write/resp handshake.
- A parallel lookup port forwards pending line data back to the cache, so a miss never reads stale memory.

Parameters:
- DEPTH, 4, number of buffered lines; power of two, at least 2.
- LINE_W, 256, line width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- evict_valid  input  1  eviction offered this cycle.
- evict_ready  output  1  buffer can accept an eviction.
- evict_address  input  32  evicted line address; bits [4:0] ignored.
- evict_data  input  LINE_W  evicted line data.
- evict_dirty  input  1  line is dirty and needs write-back.
- pmem_address  output  32  {head tag, 5'b00000}.
- pmem_wdata  output  LINE_W  head line data.
- pmem_write  output  1  write request to physical memory.
- pmem_resp  input  1  memory completed the write.
- lookup_address  input  32  cache miss address to check against pending lines.
- lookup_hit  output  1  lookup matches a pending line.
- lookup_data  output  LINE_W  data of the matching pending line.
- busy  output  1  at least one entry pending.
- count  output  $clog2(DEPTH)+1  number of pending entries.

Behaviour:
- Reset (asynchronous): empty FIFO, all entry valid bits cleared, FSM to IDLE.
  - All outputs 0, except evict_ready = 1.
  - Reset asserted during a write drops pmem_write immediately; that write is abandoned and not retried.
- Storage: per entry, tag [31:5] (27 bits), LINE_W data, valid bit. Head and tail pointers of width $clog2(DEPTH) wrap modulo DEPTH. A separate count register distinguishes full from empty.
- evict_ready = (count != DEPTH). It is purely registered-state based: a pop in the same cycle does not free a slot for a push.
- Eviction handshake: transfer occurs when evict_valid && evict_ready at posedge.
  - Clean (evict_dirty = 0): handshake completes; nothing is stored.
  - Dirty, tag matches a valid entry that is not the in-flight head: that entry's data is overwritten in place (coalesce). count is unchanged.
  - Dirty, otherwise: written at tail, tail++, count++.
- When FSM = WRITE, an incoming line whose tag equals the head tag allocates a new entry. The in-flight data is never modified.
- FSM, two states:
  - IDLE: pmem_write = 0. If count != 0, go to WRITE at the next posedge.
  - WRITE: pmem_write = 1. pmem_address and pmem_wdata come from the head entry and stay stable until pmem_resp.
    - On pmem_resp: clear head valid, head++, count--, return to IDLE.
    - This forces one deasserted cycle between consecutive writes.
    - pmem_resp seen in IDLE is ignored.
- Latency: a dirty push into an empty buffer at edge N gives pmem_write high in the cycle after edge N+1.
- Simultaneous push and pop: both take effect. count changes by net 0, or by -1 if the push coalesced.
- busy = (count != 0). count is registered.
- pmem_address and pmem_wdata are 0 when FIFO empty; otherwise they show the head entry.

Optional Feature:
- Macro: DATACACHE_WB_FORWARD_EN.
- Defined:
  - lookup_hit is combinational = lookup_address[31:5] matches any valid entry.
  - lookup_data is the youngest matching entry, i.e. the non-head match takes priority over the in-flight head.
  - Within a cycle, lookup reflects pre-edge state.
- Undefined: lookup_hit and lookup_data tied 0; comparators not built; the ports remain.

Test Plan:
- Reset: rst=1 mid-write with pmem_write=1 → pmem_write, busy, count all 0 asynchronously; evict_ready=1.
- Single dirty evict at addr 0x0000_1234, data A → pmem_write high 2 cycles later with pmem_address=0x0000_1220, pmem_wdata=A. Hold 3 cycles with no resp, then pmem_resp → count 0 next cycle, pmem_write low.
- Clean evict at addr 0x40 → evict_ready handshake only; count stays 0; pmem_write never asserts.
- Fill DEPTH=4 dirty lines at 0x100/0x200/0x300/0x400 with memory stalled → evict_ready=0; a 5th offer is not accepted. Respond to each write → writes emitted in order 0x100..0x400; ready reasserts after the first resp.
- Coalesce: queue 0x200 (data B) behind in-flight 0x100, then evict 0x200 with data C → count stays 2; the later write of 0x200 carries C. Evict 0x100 (data D) during its WRITE → new entry; memory sees 0x100 twice, first the old data, then D.
- Forwarding (macro on): pending 0x300 with data E, lookup 0x0000_0314 → lookup_hit=1, lookup_data=E same cycle. After its pmem_resp → lookup_hit=0. With macro off, lookup_hit is always 0.
